// File: rtl/microcode_store_if.sv
// Fetch and loader signal bundle for microcode_store.
// par_err is present only when MC_PARITY_EN is defined.
interface microcode_store_if;
  logic [10:0] mc_addr;
  logic [25:0] microcode;
  logic        ld_start;
  logic [10:0] ld_addr;
  logic        ld_valid;
  logic [15:0] ld_data;
  logic        ld_ready;
  logic        ld_end;
  logic        busy;
`ifdef MC_PARITY_EN
  logic        par_err;

  modport master (
    output mc_addr, ld_start, ld_addr, ld_valid, ld_data, ld_end,
    input  microcode, ld_ready, busy, par_err
  );
  modport slave (
    input  mc_addr, ld_start, ld_addr, ld_valid, ld_data, ld_end,
    output microcode, ld_ready, busy, par_err
  );
`else
  modport master (
    output mc_addr, ld_start, ld_addr, ld_valid, ld_data, ld_end,
    input  microcode, ld_ready, busy
  );
  modport slave (
    input  mc_addr, ld_start, ld_addr, ld_valid, ld_data, ld_end,
    output microcode, ld_ready, busy
  );
`endif
endinterface

// File: rtl/microcode_store.sv
// Writable 2048x26 control store: registered fetch port plus a two-beat 16-bit loader.
// Optional MC_PARITY_EN adds a stored even-parity bit and a sticky par_err output.
module microcode_store #(
  parameter int unsigned DEPTH     = 2048,
  parameter logic [25:0] HALT_WORD = 26'h0400000
) (
  input  logic              clock,
  input  logic              reset_n,
  microcode_store_if.slave  bus
);

`ifdef MC_PARITY_EN
  localparam int unsigned W = 27;
`else
  localparam int unsigned W = 26;
`endif

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LO   = 2'd1;
  localparam logic [1:0] ST_HI   = 2'd2;

  logic [1:0]   state;
  logic [10:0]  wptr;
  logic [15:0]  lo;
  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] rd_word;
  logic [W-1:0] wr_word;
  logic         open;
  logic         wr_en;

  assign open         = (state != ST_IDLE);
  assign bus.busy     = open;
  assign bus.ld_ready = open;
  assign wr_en        = open && (state == ST_HI) && bus.ld_valid;
  assign rd_word      = mem[bus.mc_addr];

`ifdef MC_PARITY_EN
  assign wr_word = {bus.ld_data[10], bus.ld_data[9:0], lo};
  logic unused_ld_bits;
  assign unused_ld_bits = &{1'b0, bus.ld_data[15:11]};
`else
  assign wr_word = {bus.ld_data[9:0], lo};
  logic unused_ld_bits;
  assign unused_ld_bits = &{1'b0, bus.ld_data[15:10]};
`endif

  // Loader FSM; ld_end in HI with a beat still commits the word before closing.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      wptr  <= '0;
      lo    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.ld_start) begin
            wptr  <= bus.ld_addr;
            state <= ST_LO;
          end
        end
        ST_LO: begin
          if (bus.ld_end) begin
            state <= ST_IDLE;
          end else if (bus.ld_valid) begin
            lo    <= bus.ld_data;
            state <= ST_HI;
          end
        end
        ST_HI: begin
          if (bus.ld_valid) begin
            wptr  <= wptr + 11'd1;
            state <= bus.ld_end ? ST_IDLE : ST_LO;
          end else if (bus.ld_end) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // RAM array is deliberately left out of reset.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wptr] <= wr_word;
  end

  // Read-first fetch register: rd_word is the pre-write contents at this edge.
`ifdef MC_PARITY_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bus.microcode <= HALT_WORD;
      bus.par_err   <= 1'b0;
    end else if (open) begin
      bus.microcode <= HALT_WORD;
    end else if (^rd_word) begin
      bus.microcode <= HALT_WORD;
      bus.par_err   <= 1'b1;
    end else begin
      bus.microcode <= rd_word[25:0];
    end
  end
`else
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bus.microcode <= HALT_WORD;
    end else if (open) begin
      bus.microcode <= HALT_WORD;
    end else begin
      bus.microcode <= rd_word;
    end
  end
`endif

endmodule

// File: tb/tb_microcode_store.sv
// Directed bench for microcode_store: load sessions, fetch table, abort/wrap/reset corners.
// Parity checks are compiled in only when MC_PARITY_EN is defined.
module tb_microcode_store;
  localparam logic [25:0] HALT = 26'h0400000;

  logic clock = 1'b0;
  logic reset_n;

  microcode_store_if bus();

  microcode_store #(.DEPTH(2048), .HALT_WORD(HALT)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  typedef struct {
    string       name;
    logic [10:0] addr;
    logic [25:0] exp;
  } vec_t;

  vec_t vecs[$];

  localparam logic [25:0] WA = 26'h0A5A5A5;
  localparam logic [25:0] WB = 26'h3FEDCBA;
  localparam logic [25:0] WC = 26'h1111111;
  localparam logic [25:0] WD = 26'h2345678;
  localparam logic [25:0] WE = 26'h0C0FFEE;
  localparam logic [25:0] WF = 26'h3000ABC;
  localparam logic [25:0] WH = 26'h1ABCDEF;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // High beat carries bits 25:16 and an even-parity bit in position 10.
  function automatic logic [15:0] hi_of(input logic [25:0] w);
    return {5'b0, ^w, w[25:16]};
  endfunction

  task automatic beat(input logic [15:0] d);
    bus.ld_valid = 1'b1;
    bus.ld_data  = d;
    tick();
    bus.ld_valid = 1'b0;
  endtask

  task automatic start(input logic [10:0] a);
    bus.ld_addr  = a;
    bus.ld_start = 1'b1;
    tick();
    bus.ld_start = 1'b0;
    check("start_busy", {31'b0, bus.busy}, 32'd1);
    check("start_ready", {31'b0, bus.ld_ready}, 32'd1);
  endtask

  task automatic word(input logic [25:0] w);
    beat(w[15:0]);
    beat(hi_of(w));
  endtask

  task automatic finish_session();
    bus.ld_end = 1'b1;
    tick();
    bus.ld_end = 1'b0;
    check("end_busy", {31'b0, bus.busy}, 32'd0);
    check("end_ready", {31'b0, bus.ld_ready}, 32'd0);
  endtask

  initial begin
    reset_n      = 1'b0;
    bus.mc_addr  = '0;
    bus.ld_start = 1'b1;
    bus.ld_addr  = 11'h123;
    bus.ld_valid = 1'b0;
    bus.ld_data  = '0;
    bus.ld_end   = 1'b0;
    tick();
    tick();
    check("rst_microcode", {6'b0, bus.microcode}, {6'b0, HALT});
    check("rst_busy", {31'b0, bus.busy}, 32'd0);
    check("rst_ready", {31'b0, bus.ld_ready}, 32'd0);
`ifdef MC_PARITY_EN
    check("rst_par_err", {31'b0, bus.par_err}, 32'd0);
`endif
    bus.ld_start = 1'b0;
    reset_n = 1'b1;
    tick();
    check("idle_after_rst", {31'b0, bus.busy}, 32'd0);

    // Load and fetch with the literal beats, checking one-edge latency.
    start(11'h010);
    beat(16'hBEEF);
    check("halt_in_session", {6'b0, bus.microcode}, {6'b0, HALT});
    beat(16'h0155);
    finish_session();
    check("halt_on_close_edge", {6'b0, bus.microcode}, {6'b0, HALT});
    bus.mc_addr = 11'h010;
    tick();
    check("fetch_010", {6'b0, bus.microcode}, 32'h0155BEEF);

    // Wrap 7FF -> 000.
    start(11'h7FF);
    word(WA);
    word(WB);
    finish_session();

    // Prefill then abort with a half word pending.
    start(11'h020);
    word(WC);
    finish_session();
    start(11'h020);
    beat(16'h1234);
    bus.ld_end = 1'b1;
    tick();
    bus.ld_end = 1'b0;
    check("abort_busy", {31'b0, bus.busy}, 32'd0);

    // ld_start during LO must not move the write pointer.
    start(11'h050);
    word(WF);
    finish_session();
    start(11'h040);
    bus.ld_addr  = 11'h050;
    bus.ld_start = 1'b1;
    tick();
    bus.ld_start = 1'b0;
    check("restart_busy", {31'b0, bus.busy}, 32'd1);
    word(WE);
    finish_session();

    // ld_end together with the HI beat commits then closes.
    start(11'h030);
    beat(WD[15:0]);
    bus.ld_valid = 1'b1;
    bus.ld_data  = hi_of(WD);
    bus.ld_end   = 1'b1;
    tick();
    bus.ld_valid = 1'b0;
    bus.ld_end   = 1'b0;
    check("end_with_beat_busy", {31'b0, bus.busy}, 32'd0);

    // ld_end in IDLE is ignored.
    bus.ld_end = 1'b1;
    tick();
    bus.ld_end = 1'b0;
    check("idle_end_busy", {31'b0, bus.busy}, 32'd0);
    check("idle_end_ready", {31'b0, bus.ld_ready}, 32'd0);

    vecs.push_back('{"fetch_010_again", 11'h010, 26'h155BEEF});
    vecs.push_back('{"wrap_7ff", 11'h7FF, WA});
    vecs.push_back('{"wrap_000", 11'h000, WB});
    vecs.push_back('{"abort_keeps_020", 11'h020, WC});
    vecs.push_back('{"end_with_beat_030", 11'h030, WD});
    vecs.push_back('{"restart_ignored_040", 11'h040, WE});
    vecs.push_back('{"restart_kept_050", 11'h050, WF});
    vecs.push_back('{"back_to_back_7ff", 11'h7FF, WA});
    for (int i = 0; i < vecs.size(); i++) begin
      bus.mc_addr = vecs[i].addr;
      tick();
      check(vecs[i].name, {6'b0, bus.microcode}, {6'b0, vecs[i].exp});
    end

    // Reset mid-session: committed data survives, pending half word lost.
    start(11'h070);
    word(WH);
    finish_session();
    start(11'h070);
    beat(16'h5555);
    reset_n = 1'b0;
    #1;
    check("midrst_busy", {31'b0, bus.busy}, 32'd0);
    check("midrst_ready", {31'b0, bus.ld_ready}, 32'd0);
    check("midrst_microcode", {6'b0, bus.microcode}, {6'b0, HALT});
    tick();
    reset_n = 1'b1;
    bus.mc_addr = 11'h070;
    tick();
    check("midrst_keeps_070", {6'b0, bus.microcode}, {6'b0, WH});

`ifdef MC_PARITY_EN
    start(11'h100);
    beat(16'h0001);
    beat(16'h0000);
    finish_session();
    bus.mc_addr = 11'h100;
    tick();
    check("par_halt", {6'b0, bus.microcode}, {6'b0, HALT});
    check("par_err_set", {31'b0, bus.par_err}, 32'd1);
    bus.mc_addr = 11'h010;
    tick();
    check("par_good_fetch", {6'b0, bus.microcode}, 32'h0155BEEF);
    check("par_err_sticky", {31'b0, bus.par_err}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("par_err_rst", {31'b0, bus.par_err}, 32'd0);
    tick();
    reset_n = 1'b1;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
